// File: rtl/instruction_stream_loader_pkg.sv
// Shared types and widths for the CPU-side I/O blocks. This package is the one
// the instruction stream loader imports.
package cpu_io_pkg;

    localparam int INSTR_WIDTH   = 32;
    localparam int IO_BYTE_WIDTH = 8;

    typedef logic [INSTR_WIDTH-1:0]   instr_word_t;
    typedef logic [IO_BYTE_WIDTH-1:0] io_byte_t;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/instruction_stream_loader_if.sv
// Byte stream input and instruction-memory write port of the loader.
// The slave side is the loader; the master side feeds bytes and observes writes.
interface instruction_stream_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    import cpu_io_pkg::*;

    logic                  io_data_valid;
    io_byte_t              io_data_packet;
    logic                  imem_write_enable;
    logic [ADDR_WIDTH-1:0] imem_write_address;
    instr_word_t           imem_write_data;

    modport master (
        output io_data_valid, io_data_packet,
        input  imem_write_enable, imem_write_address, imem_write_data
    );

    modport slave (
        input  io_data_valid, io_data_packet,
        output imem_write_enable, imem_write_address, imem_write_data
    );

endinterface

// File: rtl/instruction_stream_loader_byte_word_assembler.sv
// Collects little-endian bytes into a 32-bit word. The assembled word is
// presented combinationally in the same cycle as the 4th byte, so the caller can register it.
module byte_word_assembler
    import cpu_io_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  io_byte_t    byte_in,
    input  logic        accept,
    input  logic        flush,
    output instr_word_t word,
    output logic        word_ready
);

    logic [INSTR_WIDTH-IO_BYTE_WIDTH-1:0] shift;
    logic [1:0]                           idx;

    // NOTE: registered state is updated with <= only, so every flop samples
    // pre-edge values no matter how the statements are ordered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift <= '0;
            idx   <= '0;
        end else if (flush) begin
            shift <= '0;
            idx   <= '0;
        end else if (accept) begin
            case (idx)
                2'd0:    shift[7:0]   <= byte_in;
                2'd1:    shift[15:8]  <= byte_in;
                2'd2:    shift[23:16] <= byte_in;
                default: ;
            endcase
            idx <= idx + 2'd1;
        end
    end

    assign word       = {byte_in, shift};
    assign word_ready = accept && (idx == 2'd3);

endmodule

// File: rtl/instruction_stream_loader.sv
// In-system program loader. It parses the frame (16-bit LE word count, then LE words),
// writes the words into instruction memory, and holds the CPU while a frame is in progress.
module instruction_stream_loader
    import cpu_io_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int IMEM_DEPTH     = 256,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    instruction_stream_loader_if.slave   bus,
    input  logic                         new_instruction_write_enable,
    output logic                         cpu_hold,
    output logic                         load_done,
    output logic                         load_error
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    loader_state_t         state;
    logic [15:0]           word_count;
    logic [ADDR_WIDTH:0]   word_idx;
    logic [TW-1:0]         idle_cnt;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    instr_word_t           wr_data;
    instr_word_t           asm_word;
    logic                  asm_ready;

    logic        enable;
    logic        in_frame;
    logic        byte_accept;
    logic        timer_run;
    logic [15:0] len_full;
    logic        last_word;

    assign enable      = new_instruction_write_enable;
    assign in_frame    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
    assign byte_accept = bus.io_data_valid && enable && in_frame;
    assign timer_run   = (state == LEN_HI) || (state == DATA) || ((state == LEN_LO) && cpu_hold);
    assign len_full    = {bus.io_data_packet, word_count[7:0]};
    assign last_word   = (16'(word_idx) == (word_count - 16'd1));

    // Anything other than DATA discards a partially assembled word.
    byte_word_assembler u_assembler (
        .clk        (clk),
        .reset_n    (reset_n),
        .byte_in    (bus.io_data_packet),
        .accept     (byte_accept && (state == DATA)),
        .flush      (state != DATA),
        .word       (asm_word),
        .word_ready (asm_ready)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            word_count <= '0;
            word_idx   <= '0;
            idle_cnt   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    word_idx <= '0;
                    if (enable) state <= LEN_LO;
                end
                LEN_LO, LEN_HI, DATA: begin
                    if (!enable) begin
                        state    <= IDLE;
                        cpu_hold <= 1'b0;
                    end else if (byte_accept) begin
                        // An accepted byte beats a simultaneous timeout.
                        idle_cnt <= '0;
                        if (state == LEN_LO) begin
                            word_count[7:0] <= bus.io_data_packet;
                            cpu_hold        <= 1'b1;
                            state           <= LEN_HI;
                        end else if (state == LEN_HI) begin
                            word_count[15:8] <= bus.io_data_packet;
                            if (len_full == 16'd0) begin
                                state     <= DONE;
                                cpu_hold  <= 1'b0;
                                load_done <= 1'b1;
                            end else if (len_full > 16'(IMEM_DEPTH)) begin
                                state      <= ERROR;
                                cpu_hold   <= 1'b0;
                                load_error <= 1'b1;
                            end else begin
                                state <= DATA;
                            end
                        end else if (asm_ready) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= word_idx[ADDR_WIDTH-1:0];
                            wr_data  <= asm_word;
                            word_idx <= word_idx + 1'b1;
                            if (last_word) begin
                                state     <= DONE;
                                cpu_hold  <= 1'b0;
                                load_done <= 1'b1;
                            end
                        end
                    end else if (timer_run) begin
                        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            state      <= ERROR;
                            cpu_hold   <= 1'b0;
                            load_error <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                DONE, ERROR: begin
                    if (!enable) begin
                        state      <= IDLE;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.imem_write_enable  = wr_en;
    assign bus.imem_write_address = wr_addr;
    assign bus.imem_write_data    = wr_data;

endmodule

// File: doc/instruction_stream_loader.md
Name: instruction_stream_loader

Overview:
- Upstream neighbour of the CPU core. Consumes the byte stream on io_data_valid / io_data_packet and assembles it into 32-bit instruction words.
- Writes each word into instruction memory and holds the CPU while a program load is in progress.
- Stream frame: 2-byte little-endian word count N, then N words of 4 bytes each, little-endian.
- Replaces testbench-driven instruction preloading with an in-system loader.

Parameters:
- ADDR_WIDTH, 8, instruction memory word-address width.
- IMEM_DEPTH, 256, number of writable words; must be ≤ 2**ADDR_WIDTH.
- TIMEOUT_CYCLES, 100000, maximum idle cycles between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- io_data_valid  in  1  one-cycle strobe; io_data_packet is valid this cycle.
- io_data_packet  in  8  received byte.
- new_instruction_write_enable  in  1  level; loader armed while high.
- imem_write_enable  out  1  one-cycle write strobe to instruction memory.
- imem_write_address  out  ADDR_WIDTH  word address of the write.
- imem_write_data  out  32  assembled instruction.
- cpu_hold  out  1  high while a frame is in progress; CPU must not fetch.
- load_done  out  1  high after a complete frame; held until enable drops.
- load_error  out  1  high after a size or timeout error; held until enable drops.

Behaviour:
- Reset: all outputs 0, state IDLE, byte index 0, word counter 0, timeout counter 0.
- Byte acceptance: a byte is accepted on a rising edge where io_data_valid=1 and state is LEN_LO, LEN_HI or DATA. Bytes arriving in any other state are ignored.
- State machine:
  - IDLE → LEN_LO when new_instruction_write_enable=1.
  - LEN_LO: accept byte into count[7:0]; cpu_hold=1 from the first accepted byte onward; → LEN_HI.
  - LEN_HI: accept byte into count[15:8], then evaluate the count:
    - N=0 → DONE.
    - N>IMEM_DEPTH → ERROR.
    - otherwise → DATA.
  - DATA:
    - Byte k of each word (k=0..3) goes into shift register bits [8k+7:8k].
    - On the edge accepting byte 3, register imem_write_data, imem_write_address = word index, imem_write_enable=1 for exactly the next cycle.
    - Write latency: 1 cycle after the 4th byte is accepted.
    - Word index increments after each write. After word N-1 → DONE.
  - DONE: load_done=1, cpu_hold=0; → IDLE when enable=0.
  - ERROR: load_error=1, cpu_hold=0, no further writes; → IDLE when enable=0.
- Enable drop mid-frame (LEN_LO/LEN_HI/DATA): → IDLE next cycle.
  - cpu_hold=0; partial word discarded, no write.
  - load_done and load_error stay 0.
  - Words already written are not rolled back.
- Timeout:
  - Counter runs in LEN_HI and DATA, and in LEN_LO once cpu_hold=1; it clears on every accepted byte.
  - On reaching TIMEOUT_CYCLES-1 → ERROR. A write strobe already issued still completes.
- Simultaneous timeout and valid byte: the byte wins; the counter clears.
- Re-arm: a new frame requires enable to be low for at least one cycle (back through IDLE). load_done / load_error clear on leaving DONE / ERROR.
- Asynchronous reset mid-frame: immediate return to reset values.
- Address width:
  - Word index is an ADDR_WIDTH+1-bit counter; only the low ADDR_WIDTH bits drive the port.
  - No wrap is possible because of the N ≤ IMEM_DEPTH check.

Decomposition:
- Shared package cpu_io_pkg:
  - loader_state_t enum (IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR).
  - constants INSTR_WIDTH=32 and IO_BYTE_WIDTH=8.
  - typedef instr_word_t.
- One sub-module: byte_word_assembler. It holds the 4-byte shift register and index, takes byte_in / accept / flush, and produces word / word_ready.

Test Plan:
- Frame: enable=1; bytes 02 00 | 13 05 10 00 | 93 05 20 00 → two write pulses: addr 0 data 0x00100513, then addr 1 data 0x00200593. load_done=1, cpu_hold=0 after the last write.
- Zero-length frame: bytes 00 00 → no write, load_done=1 one cycle after the 2nd byte.
- Oversize frame: bytes 01 01 (N=257, IMEM_DEPTH=256) → load_error=1, no write. Subsequent bytes ignored.
- Timeout: bytes 01 00 AA BB, then silence (TIMEOUT_CYCLES=16) → load_error=1 exactly 16 cycles after byte BB; no write.
- Abort: enable drops after 2 data bytes → IDLE, no write, done=error=0. Re-arm with a 1-word frame → write at addr 0.
- Async reset asserted mid-DATA → all outputs 0 immediately; bytes ignored until enable is re-armed after reset release.
